// File: rtl/prefetch_op_scheduler_pkg.sv
// Shared types for the prefetcher data-queue scheduler: queue opcodes, queue error codes,
// requester indices and scheduler states.
package prefetch_op_scheduler_pkg;

    typedef enum logic [2:0] {
        OP_NOP               = 3'd0,
        OP_READ_REQ_PREF     = 3'd1,
        OP_READ_REQ_MASTER   = 3'd2,
        OP_READ_DATA_SLAVE   = 3'd3,
        OP_READ_DATA_PROMISE = 3'd4
    } opcode_e;

    localparam logic [2:0] QERR_NONE      = 3'd0;
    localparam logic [2:0] QERR_OVERFLOW  = 3'd1;
    localparam logic [2:0] QERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] QERR_PROTOCOL  = 3'd4;

    // Index order is also the fixed priority order (lowest index wins).
    typedef enum logic [1:0] {
        REQ_SR   = 2'd0,
        REQ_MAR  = 2'd1,
        REQ_PROM = 2'd2,
        REQ_PF   = 2'd3
    } req_e;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/prefetch_op_scheduler_prio_starve_arbiter.sv
// 4-way fixed-priority arbiter with saturating per-requester wait counters; a requester whose
// wait reaches the starve limit is promoted above every requester except index 0.
module prio_starve_arbiter
    import prefetch_op_scheduler_pkg::*;
#(
    parameter int STARVE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [STARVE_WIDTH-1:0] starve_limit,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      clear
);

    logic [STARVE_WIDTH-1:0] wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]      promoted;

    always_comb begin
        promoted = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            promoted[i] = (starve_limit != '0) && (wait_cnt[i] >= starve_limit);
        end
    end

    // clear[i]: no active requester ranks above i, so i would win if it requested.
    always_comb begin
        clear = '0;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            clear[i] = 1'b1;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j != i && req[j]) begin
                    if (j == 0) begin
                        clear[i] = 1'b0;
                    end else if (i != 0 &&
                                 ((promoted[j] && !promoted[i]) ||
                                  (promoted[j] == promoted[i] && j < i))) begin
                        clear[i] = 1'b0;
                    end
                end
            end
            grant[i] = req[i] && clear[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (req[i] && wait_cnt[i] != '1) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prefetch_op_scheduler.sv
// Prefetcher data-queue scheduler: arbitrates slave data, master requests, promises and prefetches
// into one registered queue opcode per cycle; owns flush and error-halt sequencing.
// Optional PREF_SCHED_STATS_EN adds per-requester grant counters and a promotion-win counter.
module prefetch_op_scheduler
    import prefetch_op_scheduler_pkg::*;
#(
    parameter int ADDR_BITS       = 64,
    parameter int BLOCK_DATA_BITS = 512,
    parameter int LOG_QUEUE_SIZE  = 6,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int STARVE_WIDTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sR_valid,
    output logic                       sR_ready,
    input  logic [BLOCK_DATA_BITS-1:0] sR_data,
    input  logic                       sR_last,
    input  logic                       mAr_valid,
    output logic                       mAr_ready,
    input  logic [ADDR_BITS-1:0]       mAr_addr,
    input  logic                       mR_ready,
    input  logic                       pf_valid,
    output logic                       pf_ready,
    input  logic [ADDR_BITS-1:0]       pf_addr,
    input  logic                       flush,
    input  logic                       errClear,
    input  logic [STARVE_WIDTH-1:0]    crs_starveLimit,
    input  logic                       q_dataReady,
    input  logic                       q_almostFull,
    input  logic [LOG_QUEUE_SIZE:0]    q_outstandingReqCnt,
    input  logic [2:0]                 q_errorCode,
    output logic [2:0]                 q_reqOpcode,
    output logic [ADDR_BITS-1:0]       q_reqAddr,
    output logic [BLOCK_DATA_BITS-1:0] q_reqData,
    output logic                       q_reqLast,
    output logic                       flushDone,
    output logic                       halted,
    output logic [2:0]                 stickyErr
`ifdef PREF_SCHED_STATS_EN
    ,
    output logic [31:0]                statGrant [NUM_REQ],
    output logic [31:0]                statStarve
`endif
);

    if (STARVE_WIDTH < 1 || BURST_LEN_WIDTH < 1) begin : g_bad_params
        $error("prefetch_op_scheduler: width parameters must be >= 1");
    end

    sched_state_e       state;
    logic               go;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] clear;

    // A live queue error blocks grants already in the cycle it appears, so nothing issues into HALT.
    assign go = !reset && (state != ST_HALT) && (q_errorCode == QERR_NONE);

    always_comb begin
        elig           = '0;
        elig[REQ_SR]   = go;
        elig[REQ_MAR]  = go && (state == ST_RUN) && !q_almostFull;
        elig[REQ_PROM] = go && mR_ready && q_dataReady;
        elig[REQ_PF]   = go && (state == ST_RUN) && !q_almostFull;
        req            = elig & {pf_valid, 1'b1, mAr_valid, sR_valid};
    end

    prio_starve_arbiter #(
        .STARVE_WIDTH (STARVE_WIDTH)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .starve_limit (crs_starveLimit),
        .grant        (grant),
        .clear        (clear)
    );

    assign sR_ready  = elig[REQ_SR]  && clear[REQ_SR];
    assign mAr_ready = elig[REQ_MAR] && clear[REQ_MAR];
    assign pf_ready  = elig[REQ_PF]  && clear[REQ_PF];
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            q_reqOpcode <= OP_NOP;
            q_reqAddr   <= '0;
            q_reqData   <= '0;
            q_reqLast   <= 1'b0;
            flushDone   <= 1'b0;
            stickyErr   <= QERR_NONE;
        end else begin
            flushDone   <= 1'b0;
            q_reqOpcode <= OP_NOP;
            q_reqAddr   <= '0;
            q_reqData   <= '0;
            q_reqLast   <= 1'b0;
            if (grant[REQ_SR]) begin
                q_reqOpcode <= OP_READ_DATA_SLAVE;
                q_reqData   <= sR_data;
                q_reqLast   <= sR_last;
            end else if (grant[REQ_MAR]) begin
                q_reqOpcode <= OP_READ_REQ_MASTER;
                q_reqAddr   <= mAr_addr;
            end else if (grant[REQ_PROM]) begin
                q_reqOpcode <= OP_READ_DATA_PROMISE;
            end else if (grant[REQ_PF]) begin
                q_reqOpcode <= OP_READ_REQ_PREF;
                q_reqAddr   <= pf_addr;
            end

            if (state != ST_HALT && q_errorCode != QERR_NONE) begin
                state     <= ST_HALT;
                stickyErr <= q_errorCode;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (flush) begin
                            state <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        if (q_outstandingReqCnt == '0) begin
                            state     <= ST_RUN;
                            flushDone <= 1'b1;
                        end
                    end
                    ST_HALT: begin
                        if (errClear) begin
                            state     <= ST_RUN;
                            stickyErr <= QERR_NONE;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

`ifdef PREF_SCHED_STATS_EN
    logic [NUM_REQ-1:0] fixed_grant;
    logic               promo_win;

    // A promotion win is any grant that plain fixed priority would have given to someone else.
    always_comb begin
        logic seen;
        seen        = 1'b0;
        fixed_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fixed_grant[i] = req[i] && !seen;
            seen           = seen || req[i];
        end
        promo_win = (grant != fixed_grant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                statGrant[i] <= '0;
            end
            statStarve <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    statGrant[i] <= statGrant[i] + 32'd1;
                end
            end
            if (promo_win) begin
                statStarve <= statStarve + 32'd1;
            end
        end
    end
`endif

endmodule
